// File: rtl/gcn_col_writer.sv
// gcn_col_writer
// Collects the two aggregated-column result streams from the layer-2
// scheduler. Each element gets a row number within its column, is buffered
// in a small dual-push FIFO, and is written to the result memory through a
// valid/ready port. Per-column completion is tracked, and o_done pulses once
// every column has been written.
//
// Optional build macro: GCN_RELU_EN. When defined, negative elements are
// stored as zero at push time (ReLU after aggregation).
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | not armed; input valids ignored
// RUN   | accepting elements, writing to memory (o_busy)
// DONE  | every column written; o_done high for this single cycle
module gcn_col_writer #(
    parameter int DATA_BITS  = 16,
    parameter int COL_LEN    = 100,
    parameter int NUM_COLS   = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_BITS  = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic                 i_col_valid_1,
    input  logic [DATA_BITS-1:0] i_col_1,
    input  logic [2:0]           i_col_idx_1,
    input  logic                 i_col_valid_2,
    input  logic [DATA_BITS-1:0] i_col_2,
    input  logic [2:0]           i_col_idx_2,
    output logic                 o_wr_valid,
    output logic [ADDR_BITS-1:0] o_wr_addr,
    output logic [DATA_BITS-1:0] o_wr_data,
    input  logic                 i_wr_ready,
    output logic [NUM_COLS-1:0]  o_col_done,
    output logic                 o_done,
    output logic                 o_overflow,
    output logic                 o_busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ROW_W = $clog2(COL_LEN + 1);
    localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(COL_LEN);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(COL_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The column and last-row flag travel with each entry so completion can
    // be tracked at pop time without dividing the address back apart.
    typedef struct packed {
        logic [ADDR_BITS-1:0] addr;
        logic [DATA_BITS-1:0] data;
        logic [2:0]           col;
        logic                 last;
    } entry_t;

    state_t             state;
    entry_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [ROW_W-1:0]   row_cnt [NUM_COLS];

    logic               pop;
    logic [CNT_W-1:0]   free_slots;
    logic               run_push;
    logic               col_ok_1, col_ok_2;
    logic [ROW_W-1:0]   row_1, row_2;
    logic               acc_1, acc_2;
    logic               drop;
    entry_t             entry_1, entry_2;
    entry_t             head;

    function automatic entry_t make_entry(input logic [2:0]           idx,
                                          input logic [ROW_W-1:0]     row,
                                          input logic [DATA_BITS-1:0] data);
        entry_t e;
        int     addr_full;
        addr_full = int'(idx) * COL_LEN + int'(row);
        e.addr = addr_full[ADDR_BITS-1:0];
`ifdef GCN_RELU_EN
        e.data = data[DATA_BITS-1] ? '0 : data;
`else
        e.data = data;
`endif
        e.col  = idx;
        e.last = (row == ROW_LAST);
        return e;
    endfunction

    // Accept/drop decision for both streams; stream 1 always claims a slot first.
    always_comb begin
        pop        = (count != '0) && i_wr_ready;
        // The slot freed by this cycle's pop is usable by this cycle's push.
        free_slots = CNT_W'(FIFO_DEPTH) - count + CNT_W'(pop);
        run_push   = (state == RUN) && !i_start;

        col_ok_1 = int'(i_col_idx_1) < NUM_COLS;
        col_ok_2 = int'(i_col_idx_2) < NUM_COLS;
        row_1    = col_ok_1 ? row_cnt[i_col_idx_1] : '0;
        row_2    = col_ok_2 ? row_cnt[i_col_idx_2] : '0;

        acc_1 = run_push && i_col_valid_1 && col_ok_1 &&
                (row_1 < ROW_MAX) && (free_slots >= CNT_W'(1));
        if (acc_1 && (i_col_idx_1 == i_col_idx_2)) begin
            row_2 = row_2 + ROW_W'(1);
        end
        acc_2 = run_push && i_col_valid_2 && col_ok_2 &&
                (row_2 < ROW_MAX) &&
                (free_slots >= (acc_1 ? CNT_W'(2) : CNT_W'(1)));

        drop = run_push && ((i_col_valid_1 && !acc_1) ||
                            (i_col_valid_2 && !acc_2));

        entry_1 = make_entry(i_col_idx_1, row_1, i_col_1);
        entry_2 = make_entry(i_col_idx_2, row_2, i_col_2);
    end

    // FIFO storage and pointers; i_start flushes any buffered entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (i_start) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (acc_1) begin
                mem[wr_ptr] <= entry_1;
            end
            if (acc_2) begin
                mem[acc_1 ? wr_ptr + PTR_W'(1) : wr_ptr] <= entry_2;
            end
            wr_ptr <= wr_ptr + PTR_W'(acc_1) + PTR_W'(acc_2);
            count  <= count + CNT_W'(acc_1) + CNT_W'(acc_2) - CNT_W'(pop);
        end
    end

    // Row counters, per-column completion and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                row_cnt[c] <= '0;
            end
            o_col_done <= '0;
            o_overflow <= 1'b0;
        end else if (i_start) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                row_cnt[c] <= '0;
            end
            o_col_done <= '0;
            o_overflow <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_COLS; c++) begin
                row_cnt[c] <= row_cnt[c]
                    + ROW_W'(acc_1 && (int'(i_col_idx_1) == c))
                    + ROW_W'(acc_2 && (int'(i_col_idx_2) == c));
            end
            if (pop && head.last) begin
                o_col_done[head.col] <= 1'b1;
            end
            if (drop) begin
                o_overflow <= 1'b1;
            end
        end
    end

    // Sequencing FSM with registered busy/done flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            o_busy <= 1'b0;
            o_done <= 1'b0;
        end else if (i_start) begin
            state  <= RUN;
            o_busy <= 1'b1;
            o_done <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (&o_col_done) begin
                        state  <= DONE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    o_done <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                    o_done <= 1'b0;
                end
            endcase
        end
    end

    // Head of the FIFO drives the write port; outputs read zero when empty.
    always_comb begin
        head       = mem[rd_ptr];
        o_wr_valid = (count != '0);
        o_wr_addr  = o_wr_valid ? head.addr : '0;
        o_wr_data  = o_wr_valid ? head.data : '0;
    end

endmodule

// File: tb/tb_gcn_col_writer.sv
// Bench for gcn_col_writer: directed vector table, hand sequences for the
// buffering/reset corners, and a randomized full-matrix run checked against
// a queue-based reference model.
module tb_gcn_col_writer;

    localparam int DATA_BITS  = 16;
    localparam int COL_LEN    = 100;
    localparam int NUM_COLS   = 8;
    localparam int FIFO_DEPTH = 8;
    localparam int ADDR_BITS  = 10;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 i_start = 1'b0;
    logic                 i_col_valid_1 = 1'b0;
    logic [DATA_BITS-1:0] i_col_1 = '0;
    logic [2:0]           i_col_idx_1 = '0;
    logic                 i_col_valid_2 = 1'b0;
    logic [DATA_BITS-1:0] i_col_2 = '0;
    logic [2:0]           i_col_idx_2 = '0;
    logic                 o_wr_valid;
    logic [ADDR_BITS-1:0] o_wr_addr;
    logic [DATA_BITS-1:0] o_wr_data;
    logic                 i_wr_ready = 1'b0;
    logic [NUM_COLS-1:0]  o_col_done;
    logic                 o_done;
    logic                 o_overflow;
    logic                 o_busy;

    gcn_col_writer #(
        .DATA_BITS(DATA_BITS), .COL_LEN(COL_LEN), .NUM_COLS(NUM_COLS),
        .FIFO_DEPTH(FIFO_DEPTH), .ADDR_BITS(ADDR_BITS)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start),
        .i_col_valid_1(i_col_valid_1), .i_col_1(i_col_1), .i_col_idx_1(i_col_idx_1),
        .i_col_valid_2(i_col_valid_2), .i_col_2(i_col_2), .i_col_idx_2(i_col_idx_2),
        .o_wr_valid(o_wr_valid), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .i_wr_ready(i_wr_ready), .o_col_done(o_col_done), .o_done(o_done),
        .o_overflow(o_overflow), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int         addr;
        logic [15:0] data;
        int         col;
        bit         last;
    } m_entry_t;

    m_entry_t    m_fifo[$];
    int          m_row[NUM_COLS];
    bit          m_ovf;
    logic [7:0]  m_coldone;
    bit          m_run;
    bit          m_done;

    bit          seen[1024];
    int          n_writes;
    int          n_dups;
    int          n_done_pulses;

    task automatic model_clear();
        m_fifo.delete();
        foreach (m_row[c]) m_row[c] = 0;
        m_ovf = 0;
        m_coldone = '0;
        m_run = 0;
        m_done = 0;
    endtask

    function automatic logic [15:0] relu(input logic [15:0] d);
`ifdef GCN_RELU_EN
        return d[15] ? 16'h0000 : d;
`else
        return d;
`endif
    endfunction

    task automatic model_push(input bit v, input int d, input int idx, inout int slots);
        m_entry_t e;
        if (!v) return;
        if (slots > 0 && idx < NUM_COLS && m_row[idx] < COL_LEN) begin
            e.addr = (idx * COL_LEN + m_row[idx]) % (1 << ADDR_BITS);
            e.data = relu(16'(d));
            e.col  = idx;
            e.last = (m_row[idx] == COL_LEN - 1);
            m_fifo.push_back(e);
            m_row[idx]++;
            slots--;
        end else begin
            m_ovf = 1;
        end
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic cycle(input bit v1, input int d1, input int i1,
                         input bit v2, input int d2, input int i2,
                         input bit rdy, input bit st);
        m_entry_t   e;
        logic [7:0] done_pre;
        int         slots;
        i_start       = st;
        i_col_valid_1 = v1; i_col_1 = 16'(d1); i_col_idx_1 = 3'(i1);
        i_col_valid_2 = v2; i_col_2 = 16'(d2); i_col_idx_2 = 3'(i2);
        i_wr_ready    = rdy;

        if (o_wr_valid && rdy && !st) begin
            if (seen[o_wr_addr]) n_dups++;
            seen[o_wr_addr] = 1;
            n_writes++;
        end

        done_pre = m_coldone;
        if (st) begin
            model_clear();
            m_run = 1;
        end else begin
            if (m_fifo.size() > 0 && rdy) begin
                e = m_fifo.pop_front();
                if (e.last) m_coldone[e.col] = 1'b1;
            end
            slots = FIFO_DEPTH - m_fifo.size();
            if (m_run) begin
                model_push(v1, d1, i1, slots);
                model_push(v2, d2, i2, slots);
            end
            if (m_run && done_pre == 8'hFF) begin
                m_run  = 0;
                m_done = 1;
            end else if (m_done) begin
                m_done = 0;
            end
        end

        @(posedge clk);
        #1;
        i_start = 1'b0;
        chk("wr_valid", o_wr_valid, m_fifo.size() > 0);
        chk("wr_addr", o_wr_addr, m_fifo.size() > 0 ? m_fifo[0].addr : 0);
        chk("wr_data", o_wr_data, m_fifo.size() > 0 ? m_fifo[0].data : 16'h0);
        chk("col_done", o_col_done, m_coldone);
        chk("overflow", o_overflow, m_ovf);
        chk("busy", o_busy, m_run);
        chk("done", o_done, m_done);
        if (o_done) n_done_pulses++;
    endtask

    task automatic idle(input bit rdy);
        cycle(0, 0, 0, 0, 0, 0, rdy, 0);
    endtask

    task automatic start();
        cycle(0, 0, 0, 0, 0, 0, 1, 1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"},    o_wr_valid, 0);
        chk({tag, "_addr"},     o_wr_addr, 0);
        chk({tag, "_data"},     o_wr_data, 0);
        chk({tag, "_col_done"}, o_col_done, 0);
        chk({tag, "_done"},     o_done, 0);
        chk({tag, "_overflow"}, o_overflow, 0);
        chk({tag, "_busy"},     o_busy, 0);
    endtask

    // Dual-push vectors, each applied right after a fresh i_start.
    typedef struct {
        int i1; int d1; int i2; int d2;
        int a1; int e1; int a2; int e2;
    } vec_t;
    vec_t vecs[4];

    initial begin : main
        int w0;
        int cyc;
        int c1, c2;
        bit all_full;

        vecs[0] = '{i1: 2, d1: 7,   i2: 5, d2: 9,   a1: 200, e1: 7,   a2: 500, e2: 9};
        vecs[1] = '{i1: 3, d1: 5,   i2: 3, d2: 6,   a1: 300, e1: 5,   a2: 301, e2: 6};
        vecs[2] = '{i1: 7, d1: 1,   i2: 1, d2: 2,   a1: 700, e1: 1,   a2: 100, e2: 2};
        vecs[3] = '{i1: 4, d1: 100, i2: 4, d2: 101, a1: 400, e1: 100, a2: 401, e2: 101};

        model_clear();
        @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Column 0, values 1..100, memory always ready.
        start();
        for (int k = 1; k <= COL_LEN; k++) cycle(1, k, 0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 3; k++) idle(1);
        chk("t1_col_done", o_col_done, 8'h01);
        chk("t1_overflow", o_overflow, 0);

        // Same-cycle dual pushes: stream 1 lands first.
        foreach (vecs[v]) begin
            start();
            cycle(1, vecs[v].d1, vecs[v].i1, 1, vecs[v].d2, vecs[v].i2, 0, 0);
            chk("vec_head1_addr", o_wr_addr, vecs[v].a1);
            chk("vec_head1_data", o_wr_data, vecs[v].e1);
            idle(1);
            chk("vec_head2_addr", o_wr_addr, vecs[v].a2);
            chk("vec_head2_data", o_wr_data, vecs[v].e2);
            idle(1);
            chk("vec_empty", o_wr_valid, 0);
        end

        // Fill with memory stalled: 8 held, two dropped, head stays put.
        start();
        for (int k = 1; k <= 10; k++) cycle(1, k, 3, 0, 0, 0, 0, 0);
        chk("t3_overflow", o_overflow, 1);
        chk("t3_head_addr", o_wr_addr, 300);
        idle(0);
        chk("t3_hold_addr", o_wr_addr, 300);
        chk("t3_hold_data", o_wr_data, 1);
        w0 = n_writes;
        for (int k = 0; k < 10; k++) idle(1);
        chk("t3_drained", n_writes - w0, 8);

        // Negative element, stored as zero only when ReLU is built in.
        start();
        cycle(1, 16'hFFF0, 1, 0, 0, 0, 0, 0);
`ifdef GCN_RELU_EN
        chk("t5_relu_data", o_wr_data, 16'h0000);
`else
        chk("t5_relu_data", o_wr_data, 16'hFFF0);
`endif
        idle(1);

        // Full matrix, random streams and random ready.
        foreach (seen[a]) seen[a] = 0;
        n_writes = 0;
        n_dups = 0;
        n_done_pulses = 0;
        start();
        cyc = 0;
        all_full = 0;
        while (!all_full && cyc < 20000) begin
            c1 = $urandom_range(NUM_COLS - 1);
            c2 = $urandom_range(NUM_COLS - 1);
            for (int t = 0; t < NUM_COLS && m_row[c1] >= COL_LEN; t++) c1 = (c1 + 1) % NUM_COLS;
            for (int t = 0; t < NUM_COLS && m_row[c2] >= COL_LEN; t++) c2 = (c2 + 1) % NUM_COLS;
            cycle($urandom_range(3) != 0, int'($urandom & 32'h7FFF), c1,
                  $urandom_range(1) != 0, int'($urandom & 32'h7FFF), c2,
                  $urandom_range(3) != 0, 0);
            cyc++;
            all_full = 1;
            foreach (m_row[c]) if (m_row[c] < COL_LEN) all_full = 0;
        end
        chk("t4_fill_in_time", all_full, 1);
        for (int k = 0; k < 40 && n_done_pulses == 0; k++) idle(1);
        idle(1);
        idle(1);
        chk("t4_writes", n_writes, NUM_COLS * COL_LEN);
        chk("t4_dups", n_dups, 0);
        chk("t4_done_pulses", n_done_pulses, 1);
        chk("t4_col_done", o_col_done, 8'hFF);
        chk("t4_busy", o_busy, 0);

        // Asynchronous reset with entries buffered, then restart.
        start();
        for (int k = 0; k < 3; k++) cycle(1, 40 + k, 6, 1, 50 + k, 2, 0, 0);
        chk("t6_pre_valid", o_wr_valid, 1);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("t6_rst");
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        start();
        cycle(1, 55, 0, 0, 0, 0, 0, 0);
        chk("t6_restart_addr", o_wr_addr, 0);
        chk("t6_restart_data", o_wr_data, 55);
        idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
